// File: rtl/two_bit_adder_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder sequencing an external carry-less 2-bit adder slice.
// Each 2-bit slice takes two passes: x+y, then partial sum + incoming carry.
module two_bit_adder_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       add_x,
  output logic [1:0]       add_y,
  input  logic [1:0]       add_z,
  input  logic             add_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int AW     = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, ADD_XY, ADD_CIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic [AW-1:0]    acc;
  logic [1:0]       tmp;
  logic             c1, cy;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] acc_nxt;
  logic [AW-1:0]    acc_shift;
  logic             cy_nxt;

  // acc holds the upper WIDTH-2 result bits; the newest slice enters at the top
  generate
    if (WIDTH > 2) begin : g_wide
      assign acc_nxt   = {add_z, acc};
      assign acc_shift = acc_nxt[WIDTH-1:2];
    end else begin : g_narrow
      assign acc_nxt   = add_z;
      assign acc_shift = '0;
    end
  endgenerate

  // c1 and the carry-in pass carry are mutually exclusive, so OR is exact
  assign cy_nxt = c1 | add_carry;

  always_comb begin
    add_x = 2'b00;
    add_y = 2'b00;
    case (state)
      ADD_XY: begin
        add_x = opa[1:0];
        add_y = opb[1:0];
      end
      ADD_CIN: begin
        add_x = tmp;
        add_y = {1'b0, cy};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      tmp       <= '0;
      c1        <= 1'b0;
      cy        <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            acc   <= '0;
            cy    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ADD_XY;
          end
        end
        ADD_XY: begin
          tmp   <= add_z;
          c1    <= add_carry;
          state <= ADD_CIN;
        end
        ADD_CIN: begin
          acc <= acc_shift;
          cy  <= cy_nxt;
          opa <= opa >> 2;
          opb <= opb >> 2;
          idx <= idx + IDXW'(1);
          if (idx == LAST) begin
            sum       <= acc_nxt;
            carry_out <= cy_nxt;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= ADD_XY;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_two_bit_adder_seq_ctrl.sv
// Bench for two_bit_adder_seq_ctrl with a behavioural 2-bit adder slice in the loop.
module tb_two_bit_adder_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] a, b;
  logic [1:0] add_x, add_y, add_z;
  logic       add_carry, busy, done, carry_out;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_dbl = 0;
  int cyc = 0;
  logic prev_done = 1'b0;
  logic [1:0] y_log [0:7];
  logic       c_log [0:7];

  always #5 clk = ~clk;

  // the external slice: z = (x+y) mod 4, carry = bit 2
  assign {add_carry, add_z} = {1'b0, add_x} + {1'b0, add_y};

  two_bit_adder_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .add_x(add_x), .add_y(add_y), .add_z(add_z), .add_carry(add_carry),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (done && prev_done) done_dbl++;
    prev_done = done;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, log slice traffic, return edges to done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] es, input logic ec);
    int n;
    start = 1'b1; a = ta; b = tb_v;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      if (n < 8) begin
        y_log[n] = add_y;
        c_log[n] = add_carry;
      end
      tick();
      n++;
    end
    check("latency", n, 8);
    check("sum", sum, es);
    check("carry_out", carry_out, ec);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_in_idle", busy, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  initial begin
    vec_t vecs [0:5];
    int d0, n, t0;
    vecs[0] = '{8'h37, 8'h2B, 8'h62, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'hC3, 8'h7E, 8'h41, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
      check("single_done", done_cnt - d0, 1);
      if (i == 1) begin
        check("ff01_cin_y0", y_log[1], 2'b00);
        for (int k = 3; k < 8; k += 2) check("ff01_cin_y", y_log[k], 2'b01);
      end
      if (i == 3) begin
        for (int k = 0; k < 8; k++) check("a55a_no_carry", c_log[k], 0);
        for (int k = 1; k < 8; k += 2) check("a55a_cin_y", y_log[k], 2'b00);
      end
    end

    // start pulse while busy, plus operand changes after capture
    d0 = done_cnt;
    start = 1'b1; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0; a = 8'hAA; b = 8'h55;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("busy_start_lat", n, 5);
    check("busy_start_sum", sum, 8'h30);
    check("busy_start_cout", carry_out, 0);
    for (int k = 0; k < 14; k++) tick();
    check("busy_start_one_done", done_cnt - d0, 1);
    check("busy_start_idle", busy, 0);

    // reset in the middle of an operation
    run_op(8'h0F, 8'h01, 8'h10, 1'b0);
    d0 = done_cnt;
    start = 1'b1; a = 8'h55; b = 8'h55;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", carry_out, 0);
    check("midrst_add_y", add_y, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_sum_held", sum, 0);
    run_op(8'h12, 8'h34, 8'h46, 1'b0);

    // start held high: back-to-back operations
    start = 1'b1; a = 8'h01; b = 8'h02;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done && n < 40) begin tick(); n++; end
      check("b2b_done_seen", done, 1);
      check("b2b_sum", sum, 8'h03);
      if (k > 0) check("b2b_period", cyc - t0, 10);
      t0 = cyc;
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("no_double_done", done_dbl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
